// File: rtl/motion_pkg.sv
// Shared types and default constants for the sprite motion controller:
// motion state encoding, facing-direction values and default playfield bounds.
package motion_pkg;

  typedef enum logic [1:0] {
    WALK      = 2'd0,
    JUMP_UP   = 2'd1,
    JUMP_DOWN = 2'd2
  } motion_state_t;

  localparam logic LEFT_DIR  = 1'b0;
  localparam logic RIGHT_DIR = 1'b1;

  localparam int DEF_X_MIN     = 0;
  localparam int DEF_X_MAX     = 600;
  localparam int DEF_Y_MIN     = 0;
  localparam int DEF_Y_MAX     = 440;
  localparam int DEF_SPAWN_X   = 320;
  localparam int DEF_SPAWN_Y   = 240;
  localparam int DEF_STEP      = 2;
  localparam int DEF_JUMP_H    = 40;
  localparam int DEF_JUMP_STEP = 4;

endpackage

// File: rtl/axis_step_clamp.sv
// One-axis position step with saturation: next = clamp(pos + delta, MIN, MAX).
// The sum is formed in a W+1-bit signed intermediate so a step below zero is
// seen as negative instead of wrapping to a large unsigned value.
module axis_step_clamp #(
  parameter int W   = 10,
  parameter int MIN = 0,
  parameter int MAX = 600
) (
  input  logic [W-1:0]        pos,
  input  logic signed [W:0]   delta,
  output logic [W-1:0]        next
);

  localparam logic signed [W:0] MIN_S = (W+1)'(MIN);
  localparam logic signed [W:0] MAX_S = (W+1)'(MAX);

  logic signed [W:0] sum;

  // Add the signed delta and saturate to the inclusive bounds
  always_comb begin
    sum  = $signed({1'b0, pos}) + delta;
    next = sum[W-1:0];
    if (sum < MIN_S) begin
      next = MIN_S[W-1:0];
    end else if (sum > MAX_S) begin
      next = MAX_S[W-1:0];
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Player-sprite motion controller: per-tick keyboard movement with playfield
// clamping, a multi-tick jump and valid/ready stage warps.
// Optional feature macro: MOTION_JUMP_EN (jump FSM, offset counter and
// key_jump edge detector). Without it key_jump is ignored, the sprite is
// always walking, jumping is 0 and warp_ready is 1.
module sprite_motion_ctrl
  import motion_pkg::*;
#(
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int STEP      = DEF_STEP,
  parameter int X_MIN     = DEF_X_MIN,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int SPAWN_X   = DEF_SPAWN_X,
  parameter int SPAWN_Y   = DEF_SPAWN_Y,
  parameter int JUMP_H    = DEF_JUMP_H,
  parameter int JUMP_STEP = DEF_JUMP_STEP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_jump,
  input  logic          freeze,
  input  logic          warp_valid,
  input  logic [XW-1:0] warp_x,
  input  logic [YW-1:0] warp_y,
  output logic          warp_ready,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          dir,
  output logic          jumping
);

  localparam logic signed [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic signed [YW:0] STEP_Y = (YW+1)'(STEP);

  logic              warp_fire;
  logic              move;
  logic signed [XW:0] dx;
  logic signed [XW:0] x_delta;
  logic signed [YW:0] dy;
  logic signed [YW:0] dy_walk;
  logic signed [YW:0] y_delta;
  logic [XW-1:0]     x_base;
  logic [XW-1:0]     x_next;
  logic [YW-1:0]     y_base;
  logic [YW-1:0]     y_next;

  assign warp_fire = warp_valid && warp_ready;
  assign move      = tick && !freeze;

  // Key-driven deltas; opposing keys cancel
  always_comb begin
    dx      = '0;
    dy_walk = '0;
    if (key_left && !key_right) begin
      dx = -STEP_X;
    end else if (key_right && !key_left) begin
      dx = STEP_X;
    end
    if (key_up && !key_down) begin
      dy_walk = -STEP_Y;
    end else if (key_down && !key_up) begin
      dy_walk = STEP_Y;
    end
  end

`ifdef MOTION_JUMP_EN
  localparam logic [YW-1:0] JH     = YW'(JUMP_H);
  localparam logic [YW-1:0] JS     = YW'(JUMP_STEP);
  localparam logic [YW-1:0] YMIN_U = YW'(Y_MIN);

  motion_state_t  state;
  logic [YW-1:0]  jump_off;
  logic           jump_hist;
  logic [YW-1:0]  up_step;
  logic [YW-1:0]  dn_step;

  // Jump step sizes: the final step is shortened to land exactly on the apex,
  // on the top wall, or back on offset 0
  always_comb begin
    up_step = JS;
    if ((JH - jump_off) < up_step) begin
      up_step = JH - jump_off;
    end
    if ((pos_y - YMIN_U) < up_step) begin
      up_step = pos_y - YMIN_U;
    end
    dn_step = (jump_off < JS) ? jump_off : JS;
    case (state)
      JUMP_UP:   dy = -$signed({1'b0, up_step});
      JUMP_DOWN: dy = $signed({1'b0, dn_step});
      default:   dy = dy_walk;
    endcase
  end

  // Jump state machine, offset tracker and key_jump history, advanced per tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WALK;
      jump_off  <= '0;
      jump_hist <= 1'b0;
    end else if (move) begin
      jump_hist <= key_jump;
      if (!warp_fire) begin
        case (state)
          WALK: begin
            if (key_jump && !jump_hist) begin
              state <= JUMP_UP;
            end
          end
          JUMP_UP: begin
            jump_off <= jump_off + up_step;
            if (((jump_off + up_step) == JH) || (y_next == YMIN_U)) begin
              state <= JUMP_DOWN;
            end
          end
          JUMP_DOWN: begin
            jump_off <= jump_off - dn_step;
            if (jump_off == dn_step) begin
              state <= WALK;
            end
          end
          default: state <= WALK;
        endcase
      end
    end
  end

  assign jumping    = (state != WALK);
  assign warp_ready = (state == WALK);
`else
  logic unused_jump;
  assign unused_jump = key_jump & (JUMP_H > 0) & (JUMP_STEP > 0);
  assign dy          = dy_walk;
  assign jumping     = 1'b0;
  assign warp_ready  = 1'b1;
`endif

  // A warp reuses the clamps with a zero delta so targets are saturated too
  assign x_base  = warp_fire ? warp_x : pos_x;
  assign x_delta = warp_fire ? '0 : dx;
  assign y_base  = warp_fire ? warp_y : pos_y;
  assign y_delta = warp_fire ? '0 : dy;

  axis_step_clamp #(.W(XW), .MIN(X_MIN), .MAX(X_MAX)) u_clamp_x (
    .pos   (x_base),
    .delta (x_delta),
    .next  (x_next)
  );

  axis_step_clamp #(.W(YW), .MIN(Y_MIN), .MAX(Y_MAX)) u_clamp_y (
    .pos   (y_base),
    .delta (y_delta),
    .next  (y_next)
  );

  // Position and facing registers; a warp wins over tick motion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x <= XW'(SPAWN_X);
      pos_y <= YW'(SPAWN_Y);
      dir   <= LEFT_DIR;
    end else if (warp_fire) begin
      pos_x <= x_next;
      pos_y <= y_next;
    end else if (move) begin
      pos_x <= x_next;
      pos_y <= y_next;
      if (dx < 0) begin
        dir <= LEFT_DIR;
      end else if (dx > 0) begin
        dir <= RIGHT_DIR;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl (default parameters). Each driven
// cycle pushes the model's expected outputs; tasks pop and compare them at
// the following falling edge. Jump scenarios follow MOTION_JUMP_EN.
module tb_sprite_motion_ctrl;

`ifdef MOTION_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef logic [22:0] obs_t;  // {x[9:0], y[9:0], dir, jumping, warp_ready}

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, key_left, key_right, key_up, key_down, key_jump;
  logic       freeze, warp_valid;
  logic [9:0] warp_x, warp_y;
  logic       warp_ready;
  logic [9:0] pos_x, pos_y;
  logic       dir, jumping;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t exp_q[$];

  // model state
  int mx, my, moff, ms;
  bit mdir, mh;

  sprite_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_jump(key_jump), .freeze(freeze),
    .warp_valid(warp_valid), .warp_x(warp_x), .warp_y(warp_y),
    .warp_ready(warp_ready), .pos_x(pos_x), .pos_y(pos_y),
    .dir(dir), .jumping(jumping)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    mx = 320; my = 240; moff = 0; ms = 0; mdir = 1'b0; mh = 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o = {mx[9:0], my[9:0], mdir, (ms != 0), (ms == 0)};
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {pos_x, pos_y, dir, jumping, warp_ready};
    return o;
  endfunction

  function automatic string show(obs_t o);
    return $sformatf("(x=%0d y=%0d dir=%0d jmp=%0d rdy=%0d)",
                     o[22:13], o[12:3], o[2], o[1], o[0]);
  endfunction

  // Reference behaviour for one clock edge
  function automatic void model_cycle(bit t, bit l, bit r, bit u, bit d, bit j,
                                      bit frz, bit wv, int wx, int wy);
    bit fire;
    int stp;
    fire = wv && (ms == 0);
    if (fire) begin
      mx = clampi(wx, 0, 600);
      my = clampi(wy, 0, 440);
    end
    if (t && !frz) begin
      if (!fire) begin
        if (l && !r) begin mx = clampi(mx - 2, 0, 600); mdir = 1'b0; end
        else if (r && !l) begin mx = clampi(mx + 2, 0, 600); mdir = 1'b1; end
        if (ms == 0) begin
          if (u && !d) my = clampi(my - 2, 0, 440);
          else if (d && !u) my = clampi(my + 2, 0, 440);
          if (JUMP_EN && j && !mh) ms = 1;
        end else if (ms == 1) begin
          stp = 4;
          if (40 - moff < stp) stp = 40 - moff;
          if (my < stp) stp = my;
          my -= stp; moff += stp;
          if (moff == 40 || my == 0) ms = 2;
        end else begin
          stp = (moff < 4) ? moff : 4;
          my += stp; moff -= stp;
          if (moff == 0) ms = 0;
        end
      end
      mh = j;
    end
  endfunction

  // Drive one cycle of stimulus, record the expectation, wait for the result
  task automatic drive(input bit t, input bit l, input bit r, input bit u,
                       input bit d, input bit j, input bit frz, input bit wv,
                       input int wx = 0, input int wy = 0);
    tick = t; key_left = l; key_right = r; key_up = u; key_down = d;
    key_jump = j; freeze = frz; warp_valid = wv;
    warp_x = wx[9:0]; warp_y = wy[9:0];
    model_cycle(t, l, r, u, d, j, frz, wv, wx, wy);
    exp_q.push_back(model_obs());
    @(negedge clk);
    tick = 1'b0;
    warp_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t want;
    want = {10'd320, 10'd240, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (dut_obs() !== want) begin
      n_bad++;
      $display("FAIL reset: got %s expected %s", show(dut_obs()), show(want));
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_walk();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_bad++;
        $display("FAIL walk_right[%0d]: got %s expected %s", i, show(dut_obs()), show(e));
      end
      drive(0, 1, 0, 1, 0, 0, 0, 0);  // keys without tick: must hold
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_bad++;
        $display("FAIL walk_hold[%0d]: got %s expected %s", i, show(dut_obs()), show(e));
      end
    end
    n_cmp++;
    if (pos_x !== 10'd330 || pos_y !== 10'd240 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL walk_final: got x=%0d y=%0d dir=%0d expected x=330 y=240 dir=1",
               pos_x, pos_y, dir);
    end
  endtask

  task automatic test_clamp();
    obs_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 599, 240);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1023, 1023);
    drive(1, 0, 1, 0, 1, 0, 0, 0);
    // pop in order; each entry matches the DUT output after that cycle only
    // when popped right away, so all drives above are re-checked via final
    // values below and the queue is drained against the last sample
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e) begin
      n_bad++;
      $display("FAIL clamp_max: got %s expected %s", show(dut_obs()), show(e));
    end
    n_cmp++;
    if (pos_x !== 10'd600 || pos_y !== 10'd440) begin
      n_bad++;
      $display("FAIL clamp_warp_sat: got x=%0d y=%0d expected x=600 y=440", pos_x, pos_y);
    end
    // step-by-step edge checks
    drive(0, 0, 0, 0, 0, 0, 0, 1, 599, 1);
    drive(1, 0, 1, 1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || pos_x !== 10'd600 || pos_y !== 10'd0) begin
      n_bad++;
      $display("FAIL clamp_edge: got %s expected %s (x=600 y=0)", show(dut_obs()), show(e));
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e) begin
      n_bad++;
      $display("FAIL clamp_both_keys: got %s expected %s", show(dut_obs()), show(e));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || pos_x !== 10'd0 || pos_y !== 10'd0 || dir !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_min: got %s expected %s", show(dut_obs()), show(e));
    end
  endtask

  task automatic test_freeze_warp();
    obs_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 320, 240);
    void'(exp_q.pop_front());
    drive(1, 0, 1, 0, 1, 1, 1, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e) begin
      n_bad++;
      $display("FAIL freeze_hold: got %s expected %s", show(dut_obs()), show(e));
    end
    drive(1, 1, 0, 0, 0, 0, 1, 1, 250, 80);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || pos_x !== 10'd250 || pos_y !== 10'd80) begin
      n_bad++;
      $display("FAIL freeze_warp: got %s expected %s (250,80)", show(dut_obs()), show(e));
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);  // clears jump history
    void'(exp_q.pop_front());
  endtask

`ifdef MOTION_JUMP_EN
  task automatic test_jump();
    obs_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 320, 240);
    void'(exp_q.pop_front());
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || jumping !== 1'b1 || warp_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL jump_start: got %s expected %s", show(dut_obs()), show(e));
    end
    // warp held valid throughout: must wait for WALK
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0, 1, 250, 80);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_bad++;
        $display("FAIL jump_tick[%0d]: got %s expected %s", i, show(dut_obs()), show(e));
      end
      if (i == 9) begin
        n_cmp++;
        if (pos_y !== 10'd200 || jumping !== 1'b1) begin
          n_bad++;
          $display("FAIL jump_apex: got y=%0d jmp=%0d expected y=200 jmp=1", pos_y, jumping);
        end
      end
    end
    n_cmp++;
    if (pos_y !== 10'd240 || jumping !== 1'b0 || warp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL jump_land: got y=%0d jmp=%0d rdy=%0d expected y=240 jmp=0 rdy=1",
               pos_y, jumping, warp_ready);
    end
    drive(1, 0, 0, 0, 0, 1, 0, 1, 250, 80);
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e || pos_x !== 10'd250 || pos_y !== 10'd80) begin
      n_bad++;
      $display("FAIL jump_warp_after: got %s expected %s", show(dut_obs()), show(e));
    end
  endtask

  task automatic test_jump_low();
    obs_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 100, 20);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_bad++;
        $display("FAIL jump_low[%0d]: got %s expected %s", i, show(dut_obs()), show(e));
      end
      if (i == 4) begin
        n_cmp++;
        if (pos_y !== 10'd0 || jumping !== 1'b1) begin
          n_bad++;
          $display("FAIL jump_low_top: got y=%0d jmp=%0d expected y=0 jmp=1", pos_y, jumping);
        end
      end
    end
    n_cmp++;
    if (pos_y !== 10'd20 || jumping !== 1'b0 || pos_x !== 10'd120) begin
      n_bad++;
      $display("FAIL jump_low_land: got x=%0d y=%0d jmp=%0d expected x=120 y=20 jmp=0",
               pos_x, pos_y, jumping);
    end
  endtask

  task automatic test_reset_mid_jump();
    obs_t e;
    obs_t want;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e) begin
      n_bad++;
      $display("FAIL prereset_jump: got %s expected %s", show(dut_obs()), show(e));
    end
    #2 rst_n = 1'b0;
    #1;
    want = {10'd320, 10'd240, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (dut_obs() !== want) begin
      n_bad++;
      $display("FAIL reset_mid_jump: got %s expected %s", show(dut_obs()), show(want));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0);  // history cleared: this is a fresh edge
    e = exp_q.pop_front();
    n_cmp++;
    if (dut_obs() !== e) begin
      n_bad++;
      $display("FAIL post_reset_jump: got %s expected %s", show(dut_obs()), show(e));
    end
  endtask
`else
  task automatic test_jump_disabled();
    obs_t e;
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (i == 2 && (dut_obs() !== e || jumping !== 1'b0 || warp_ready !== 1'b1)) begin
        n_bad++;
        $display("FAIL jump_disabled: got %s expected %s", show(dut_obs()), show(e));
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs() !== e) begin
        n_bad++;
        $display("FAIL random[%0d]: got %s expected %s", i, show(dut_obs()), show(e));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 0; key_left = 0; key_right = 0; key_up = 0; key_down = 0;
    key_jump = 0; freeze = 0; warp_valid = 0; warp_x = '0; warp_y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_walk();
    test_clamp();
    test_freeze_warp();
`ifdef MOTION_JUMP_EN
    test_jump();
    test_jump_low();
    test_reset_mid_jump();
`else
    test_jump_disabled();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Parametrised player-sprite motion controller sitting between the keyboard decoder and the VGA sprite renderer. It advances a sprite position once per movement tick from direction keys, clamps the result to a configurable playfield and runs a multi-tick jump state machine. It also accepts stage-transition warps through a valid/ready handshake, replacing per-stage hard-coded teleport logic.

## Interface
- XW, 10, x position width
- YW, 10, y position width
- STEP, 2, pixels per tick per axis
- X_MIN / X_MAX, 0 / 600, inclusive x bounds (sprite left edge)
- Y_MIN / Y_MAX, 0 / 440, inclusive y bounds (sprite top edge)
- SPAWN_X / SPAWN_Y, 320 / 240, reset position
- JUMP_H, 40, jump apex height in pixels
- JUMP_STEP, 4, jump pixels per tick

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle movement enable (frame rate)
- key_left, key_right, key_up, key_down, key_jump  in  1 each  level key states
- freeze  in  1  hold all motion (fail, success, cutscene)
- warp_valid  in  1  warp request
- warp_x  in  XW  warp target x
- warp_y  in  YW  warp target y
- warp_ready  out  1  high when a warp can be accepted
- pos_x  out  XW  sprite x
- pos_y  out  YW  sprite y
- dir  out  1  facing, 0 = left, 1 = right
- jumping  out  1  high in JUMP_UP or JUMP_DOWN

## Operation
- Reset values: pos_x = SPAWN_X, pos_y = SPAWN_Y, dir = 0, state = WALK, jump offset = 0, key_jump history = 0, warp_ready = 1.
- States:
  - WALK → JUMP_UP on a key_jump rising edge sampled on a tick, with freeze low.
  - JUMP_UP → JUMP_DOWN when offset reaches JUMP_H or pos_y reaches Y_MIN.
  - JUMP_DOWN → WALK when offset returns to 0.
- Horizontal motion per tick when not frozen:
  - key_left alone: x −= STEP, dir = 0.
  - key_right alone: x += STEP, dir = 1.
  - Both or neither: no x change, dir held.
- Vertical motion is the same rule with key_up (−) and key_down (+), applied in WALK only. In jump states the jump owns y; horizontal motion still applies.
- Jump: each tick pos_y −= JUMP_STEP (UP) or += JUMP_STEP (DOWN), with offset tracked. The last step is truncated so the offset lands exactly on JUMP_H, and lands exactly on 0 on the way down.
- Clamp: arithmetic uses XW+1 / YW+1 bit signed intermediates. Results below MIN saturate to MIN; results above MAX saturate to MAX. The value never wraps.
- Warp: warp_ready = (state == WALK). On warp_valid && warp_ready the position loads warp_x/warp_y (clamped) on that edge. A warp has priority over tick motion in the same cycle. dir is unchanged. Warps are accepted even while freeze is high.
- Freeze: position, dir, state and offset all hold; jump-edge detection is suppressed.

## Timing
- Position updates on the clk edge where tick = 1; outputs are registered, so the response appears 1 cycle after the tick.
- A warp appears on pos_x/pos_y one cycle after the handshake edge.
- warp_ready drops in the cycle after JUMP_UP is entered.
- A jump of height H takes ceil(H/JUMP_STEP) ticks up plus the same number down.
- Reset asserted mid-jump returns to spawn/WALK immediately (asynchronously); no residual offset remains.

## Configuration
- MOTION_JUMP_EN defined: jump states, offset counter and key_jump edge detector are present.
- MOTION_JUMP_EN undefined: key_jump is ignored, state is always WALK, jumping is tied to 0, and warp_ready is tied to 1.

## Structure
- motion_pkg holds:
  - state enum (WALK, JUMP_UP, JUMP_DOWN)
  - LEFT_DIR = 0 and RIGHT_DIR = 1
  - default bound constants
- One sub-module, axis_step_clamp (parametrised width, MIN, MAX): inputs are current position and signed delta; output is the saturated next position. Instantiate one per axis.

## Test plan
- Reset, then hold key_right for 5 ticks → pos_x = 330, dir = 1; pos_y stays 240.
- Start at x = 599 and hold key_right for 1 tick → pos_x = 600 (clamped). key_left+key_right held together → no change.
- key_jump edge at y = 240 → y steps 236, 232 … 200 over 10 ticks, then back to 240 over 10 ticks; jumping is high throughout and warp_ready is low.
- Jump started at y = 20 → UP stops at y = 0 after 5 ticks, then DOWN returns to 20.
- warp_valid with (250, 80) while in WALK and freeze = 1 → position is (250, 80) next cycle; a warp during a jump is held until WALK.
- Assert rst_n low mid-jump → outputs read (320, 240), dir = 0, jumping = 0 immediately.
